// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with bounded hold and turnaround gap, driving decoder_24 w/EN
module rr_arbiter_4 #(
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] w,
  output logic       EN,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t     state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;
  logic [3:0] rot;
  logic [1:0] pick;
  logic       rel;
  always_comb begin
    rot = '0;
    for (int i = 0; i < 4; i++) rot[i] = req[ptr + 2'(i)];
    pick = ptr + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
    rel  = !req[w] || hold_cnt == 8'(MAX_HOLD);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      w        <= 2'b00;
      EN       <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= 2'b00;
      hold_cnt <= 8'd0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: if (req != 4'b0000) begin
          w        <= pick;
          EN       <= 1'b1;
          hold_cnt <= 8'd1;
          state    <= GRANT;
        end
        GRANT: if (rel) begin
          EN       <= 1'b0;
          timeout  <= req[w];
          ptr      <= w + 2'd1;
          hold_cnt <= 8'd0;
          state    <= (TURNAROUND > 0) ? GAP : IDLE;
        end else hold_cnt <= hold_cnt + 8'd1;
        GAP: if (hold_cnt == 8'(TURNAROUND - 1)) begin
          hold_cnt <= 8'd0;
          state    <= IDLE;
        end else hold_cnt <= hold_cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
